// File: rtl/mic_boxcar_decimator.sv
// Boxcar decimator: averages 2^LOG2_DEC receiver samples and presents each mean on a valid/ready port.
// Optional DC-blocking IIR on the output, enabled by defining MIC_BOXCAR_DC_BLOCK_EN.
module mic_boxcar_decimator #(
    parameter int unsigned LOG2_DEC         = 2,
    parameter bit          IN_OFFSET_BINARY = 1'b1,
    parameter int unsigned DC_SHIFT         = 10
) (
    input  logic        dclk,
    input  logic        rstn,
    input  logic        en,
    input  logic [17:0] din,
    input  logic        drdy,
    output logic [17:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        ovr,
    input  logic        ovr_clr
);

    localparam int unsigned DW = 18;
    localparam int unsigned AW = DW + LOG2_DEC;
    localparam int unsigned CW = (LOG2_DEC == 0) ? 1 : LOG2_DEC;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_DEC) - 1);

    if (LOG2_DEC > 6 || DC_SHIFT > 24) begin : g_bad_cfg
        $error("mic_boxcar_decimator: LOG2_DEC must be 0..6 and DC_SHIFT 0..24");
    end

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic                   drdy_q;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic        [CW-1:0]   cnt_q, cnt_d;
    logic        [DW-1:0]   out_data_q, out_data_d;
    logic                   ovr_q, ovr_d;

    logic                   take_c;
    logic                   done_c;
    logic signed [DW-1:0]   samp_c;
    logic signed [AW-1:0]   sum_c;
    logic signed [DW-1:0]   mean_c;
    logic signed [DW-1:0]   res_c;

    // New sample only on the rising edge of the receiver's data-ready level.
    assign take_c = drdy & ~drdy_q & en;
    assign done_c = take_c && (cnt_q == CNT_LAST);

    assign samp_c = IN_OFFSET_BINARY ? {~din[DW-1], din[DW-2:0]} : din;
    assign sum_c  = acc_q + AW'(samp_c);
    // Arithmetic shift gives floor rounding; the mean of DW-bit samples always fits DW bits.
    assign mean_c = DW'(sum_c >>> LOG2_DEC);

`ifdef MIC_BOXCAR_DC_BLOCK_EN
    localparam int unsigned DCW = DW + DC_SHIFT;
    localparam int unsigned DXW = DW + 1;

    logic signed [DCW-1:0]  dc_q, dc_d;
    logic signed [DW-1:0]   est_c;
    logic signed [DXW-1:0]  diff_c;

    assign est_c  = DW'(dc_q >>> DC_SHIFT);
    assign diff_c = DXW'(mean_c) - DXW'(est_c);

    // Saturate the DC-corrected mean back into the 18-bit signed range.
    always_comb begin
        res_c = diff_c[DW-1:0];
        if (diff_c[DXW-1] != diff_c[DW-1]) begin
            res_c = diff_c[DXW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

    always_comb begin
        dc_d = dc_q;
        if (done_c) begin
            dc_d = dc_q + DCW'(mean_c) - DCW'(est_c);
        end
    end

    always_ff @(posedge dclk) begin
        if (!rstn) begin
            dc_q <= '0;
        end else begin
            dc_q <= dc_d;
        end
    end
`else
    assign res_c = mean_c;
`endif

    // Accumulator and sample counter; en low discards any partial block.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (!en) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (take_c) begin
            if (done_c) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_c;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge dclk) begin
        if (!rstn) begin
            drdy_q <= 1'b0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else begin
            drdy_q <= drdy;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge dclk) begin
        if (!rstn) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (done_c)                state_d = ST_FULL;
            ST_FULL:  if (out_ready && !done_c)  state_d = ST_EMPTY;
            default:                             state_d = ST_EMPTY;
        endcase
    end

    // A result loads when the slot is free or being drained; otherwise it is dropped and flagged.
    always_comb begin
        out_data_d = out_data_q;
        ovr_d      = ovr_q;
        if (ovr_clr) begin
            ovr_d = 1'b0;
        end
        case (state_q)
            ST_EMPTY: begin
                if (done_c) out_data_d = res_c;
            end
            ST_FULL: begin
                if (done_c && out_ready)  out_data_d = res_c;
                if (done_c && !out_ready) ovr_d      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge dclk) begin
        if (!rstn) begin
            out_data_q <= '0;
            ovr_q      <= 1'b0;
        end else begin
            out_data_q <= out_data_d;
            ovr_q      <= ovr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = (state_q == ST_FULL);
    assign ovr       = ovr_q;

endmodule

// File: tb/tb_mic_boxcar_decimator.sv
// Bench for mic_boxcar_decimator: two instances (4:1 two's complement, 1:1 offset-binary)
// driven by directed steps, with expected means queued and checked as the outputs are consumed.
module tb_mic_boxcar_decimator;

    logic dclk = 1'b0;
    always #5 dclk = ~dclk;

    logic        rstn;
    logic        en_a, drdy_a, ready_a, ovr_clr_a;
    logic [17:0] din_a;
    logic [17:0] data_a;
    logic        valid_a, ovr_a;
    logic        en_b, drdy_b, ready_b, ovr_clr_b;
    logic [17:0] din_b;
    logic [17:0] data_b;
    logic        valid_b, ovr_b;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_a[$];
    logic [17:0] exp_b[$];
    bit dc_mode = 1'b0;

    mic_boxcar_decimator #(.LOG2_DEC(2), .IN_OFFSET_BINARY(1'b0), .DC_SHIFT(10)) u_dut_a (
        .dclk(dclk), .rstn(rstn), .en(en_a), .din(din_a), .drdy(drdy_a),
        .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a),
        .ovr(ovr_a), .ovr_clr(ovr_clr_a)
    );

    mic_boxcar_decimator #(.LOG2_DEC(0), .IN_OFFSET_BINARY(1'b1), .DC_SHIFT(4)) u_dut_b (
        .dclk(dclk), .rstn(rstn), .en(en_b), .din(din_b), .drdy(drdy_b),
        .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b),
        .ovr(ovr_b), .ovr_clr(ovr_clr_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic sample_a(input logic [17:0] v);
        din_a  = v;
        drdy_a = 1'b1;
        tick();
        drdy_a = 1'b0;
        tick();
    endtask

    task automatic sample_b(input logic [17:0] v);
        din_b  = v;
        drdy_b = 1'b1;
        tick();
        drdy_b = 1'b0;
        tick();
    endtask

    // Scoreboard: each accepted output pops the oldest expected mean.
    always @(negedge dclk) begin
        if (rstn && valid_a && ready_a) begin
            if (exp_a.size() == 0) chk("a_unexpected_out", 32'(valid_a), 32'd0);
            else                   chk("a_out", 32'(data_a), 32'(exp_a.pop_front()));
        end
        if (rstn && !dc_mode && valid_b && ready_b) begin
            if (exp_b.size() == 0) chk("b_unexpected_out", 32'(valid_b), 32'd0);
            else                   chk("b_out", 32'(data_b), 32'(exp_b.pop_front()));
        end
    end

    initial begin
        rstn = 1'b0;
        en_a = 1'b0; drdy_a = 1'b0; ready_a = 1'b0; ovr_clr_a = 1'b0; din_a = '0;
        en_b = 1'b0; drdy_b = 1'b0; ready_b = 1'b0; ovr_clr_b = 1'b0; din_b = '0;
        repeat (3) tick();
        chk("rst_a_data", 32'(data_a), 32'd0);
        chk("rst_a_valid", 32'(valid_a), 32'd0);
        chk("rst_a_ovr", 32'(ovr_a), 32'd0);
        chk("rst_b_data", 32'(data_b), 32'd0);
        chk("rst_b_valid", 32'(valid_b), 32'd0);
        chk("rst_b_ovr", 32'(ovr_b), 32'd0);
        rstn = 1'b1;
        en_a = 1'b1; ready_a = 1'b1;
        en_b = 1'b1; ready_b = 1'b1;
        tick();

`ifdef MIC_BOXCAR_DC_BLOCK_EN
        begin
            logic signed [17:0] sv;
            int prev, cur;
            dc_mode = 1'b1;
            prev = 1000;
            for (int i = 0; i < 200; i++) begin
                sample_b(18'd1000 ^ 18'h20000);
                sv  = data_b;
                cur = sv;
                if (i == 0) chk("dc_first", 32'(cur), 32'd1000);
                else        chk("dc_monotonic", 32'(cur <= prev), 32'd1);
                prev = cur;
            end
            chk("dc_settled", 32'((prev <= 2) && (prev >= -2)), 32'd1);
        end
`else
        // 4:1 mean of 4,8,12,16; nothing after the first three samples.
        sample_a(18'd4); sample_a(18'd8); sample_a(18'd12);
        chk("a_no_early_valid", 32'(valid_a), 32'd0);
        exp_a.push_back(18'd10);
        sample_a(18'd16);
        chk("a_valid_pulse_done", 32'(valid_a), 32'd0);

        // Floor rounding: sum -5 -> -2.
        exp_a.push_back(18'h3FFFE);
        sample_a(18'h3FFFF); sample_a(18'h3FFFF); sample_a(18'h3FFFF); sample_a(18'h3FFFE);

        // Offset-binary pass-through: midscale, full-scale positive, full-scale negative.
        exp_b.push_back(18'h00000); sample_b(18'h20000);
        exp_b.push_back(18'h1FFFF); sample_b(18'h3FFFF);
        exp_b.push_back(18'h20000); sample_b(18'h00000);

        // Backpressure: second block dropped, ovr set, then cleared and first result drained.
        ready_a = 1'b0;
        repeat (4) sample_a(18'd5);
        chk("ovr_first_valid", 32'(valid_a), 32'd1);
        chk("ovr_first_data", 32'(data_a), 32'd5);
        repeat (4) sample_a(18'd9);
        chk("ovr_data_held", 32'(data_a), 32'd5);
        chk("ovr_set", 32'(ovr_a), 32'd1);
        ovr_clr_a = 1'b1; tick(); ovr_clr_a = 1'b0;
        chk("ovr_cleared", 32'(ovr_a), 32'd0);
        exp_a.push_back(18'd5);
        ready_a = 1'b1;
        tick(); tick();
        chk("ovr_drained_valid", 32'(valid_a), 32'd0);

        // drdy held high for 10 cycles is one sample.
        exp_a.push_back(18'd3);
        din_a = 18'd3; drdy_a = 1'b1;
        repeat (10) tick();
        drdy_a = 1'b0; tick();
        sample_a(18'd3); sample_a(18'd3);
        chk("held_no_early_valid", 32'(valid_a), 32'd0);
        sample_a(18'd3);

        // en dropped mid-block discards the partial sum.
        sample_a(18'd1); sample_a(18'd1);
        en_a = 1'b0; tick(); tick(); en_a = 1'b1;
        exp_a.push_back(18'd7);
        repeat (4) sample_a(18'd7);

        // Reset mid-block: outputs cleared, next result from post-reset samples only.
        repeat (3) sample_a(18'd100);
        rstn = 1'b0; tick();
        chk("midrst_data", 32'(data_a), 32'd0);
        chk("midrst_valid", 32'(valid_a), 32'd0);
        chk("midrst_ovr", 32'(ovr_a), 32'd0);
        rstn = 1'b1; tick();
        exp_a.push_back(18'd2);
        repeat (4) sample_a(18'd2);
`endif

        repeat (4) tick();
        chk("a_all_results_seen", 32'(exp_a.size()), 32'd0);
        chk("b_all_results_seen", 32'(exp_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
